// File: rtl/inertial_pulse_filter.sv
// Clocked inertial filter for the asynchronous decode-gate output F: synchronises it,
// drops pulses shorter than MIN_WIDTH clocks, strobes accepted edges and counts edges/glitches.
module inertial_pulse_filter #(
    parameter int   MIN_WIDTH = 3,
    parameter int   CNT_W     = 8,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             f_in,
    input  logic             en,
    input  logic             clr_counts,
    output logic             f_out,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic [CNT_W-1:0] edge_count,
    output logic [CNT_W-1:0] glitch_count,
    output logic             glitch_sat
);

    localparam int CW = $clog2(MIN_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(MIN_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {STABLE, CANDIDATE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sync0_q, sync0_d;
    logic             sync1_q, sync1_d;
    logic             f_out_q, f_out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;
    logic [CNT_W-1:0] glitch_count_q, glitch_count_d;
    logic             glitch_sat_q, glitch_sat_d;
    logic             accept;
    logic             glitch;

    always_comb begin
        sync0_d = f_in;
        sync1_d = sync0_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        f_out_d = f_out_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        accept  = 1'b0;
        glitch  = 1'b0;

        // Dropping en abandons any candidate; the run restarts once en returns.
        if (!en) begin
            state_d = STABLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                STABLE: begin
                    if (sync1_q != f_out_q) begin
                        state_d = CANDIDATE;
                        cnt_d   = CW'(1);
                    end
                end
                CANDIDATE: begin
                    if (sync1_q == f_out_q) begin
                        glitch  = 1'b1;
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == LAST_CNT) begin
                        accept  = 1'b1;
                        f_out_d = sync1_q;
                        rise_d  = sync1_q;
                        fall_d  = ~sync1_q;
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        edge_count_d   = edge_count_q;
        glitch_count_d = glitch_count_q;
        glitch_sat_d   = glitch_sat_q;

        // A clear in the same cycle as an increment discards the increment.
        if (clr_counts) begin
            edge_count_d   = '0;
            glitch_count_d = '0;
            glitch_sat_d   = 1'b0;
        end else begin
            if (accept) begin
                edge_count_d = edge_count_q + CNT_W'(1);
            end
            if (glitch && (glitch_count_q != CNT_MAX)) begin
                glitch_count_d = glitch_count_q + CNT_W'(1);
                if (glitch_count_d == CNT_MAX) begin
                    glitch_sat_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync0_q        <= RESET_VAL;
            sync1_q        <= RESET_VAL;
            f_out_q        <= RESET_VAL;
            state_q        <= STABLE;
            cnt_q          <= '0;
            rise_q         <= 1'b0;
            fall_q         <= 1'b0;
            edge_count_q   <= '0;
            glitch_count_q <= '0;
            glitch_sat_q   <= 1'b0;
        end else begin
            sync0_q        <= sync0_d;
            sync1_q        <= sync1_d;
            f_out_q        <= f_out_d;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            rise_q         <= rise_d;
            fall_q         <= fall_d;
            edge_count_q   <= edge_count_d;
            glitch_count_q <= glitch_count_d;
            glitch_sat_q   <= glitch_sat_d;
        end
    end

    assign f_out        = f_out_q;
    assign rise_pulse   = rise_q;
    assign fall_pulse   = fall_q;
    assign edge_count   = edge_count_q;
    assign glitch_count = glitch_count_q;
    assign glitch_sat   = glitch_sat_q;

endmodule

// File: tb/tb_inertial_pulse_filter.sv
// Scoreboard bench for inertial_pulse_filter: a run-length reference model predicts the
// outputs after every clock edge; a monitor compares them against the DUT on the falling edge.
module tb_inertial_pulse_filter;

    localparam int   MIN_WIDTH = 3;
    localparam int   CNT_W     = 8;
    localparam logic RESET_VAL = 1'b1;

    typedef struct packed {
        logic             f_out;
        logic             rise;
        logic             fall;
        logic [CNT_W-1:0] edges;
        logic [CNT_W-1:0] glitches;
        logic             sat;
    } snap_t;

    logic             clk;
    logic             rst;
    logic             f_in;
    logic             en;
    logic             clr_counts;
    logic             f_out;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] edge_count;
    logic [CNT_W-1:0] glitch_count;
    logic             glitch_sat;

    snap_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cycle = 0;

    // Reference model state: the level seen by the filter lags f_in by two samples, and
    // acceptance is decided purely by how many consecutive enabled samples differ from f_out.
    logic m_s0, m_s1, m_fout, m_rise, m_fall, m_sat;
    int   m_run, m_edges, m_glitches;

    inertial_pulse_filter #(
        .MIN_WIDTH(MIN_WIDTH),
        .CNT_W(CNT_W),
        .RESET_VAL(RESET_VAL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .f_in(f_in),
        .en(en),
        .clr_counts(clr_counts),
        .f_out(f_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .edge_count(edge_count),
        .glitch_count(glitch_count),
        .glitch_sat(glitch_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs that edge samples.
    task automatic updateModel(input logic r, input logic fi, input logic e, input logic c);
        logic seen;
        bit   inc_e;
        bit   inc_g;
        if (r) begin
            m_s0 = RESET_VAL; m_s1 = RESET_VAL; m_fout = RESET_VAL;
            m_rise = 1'b0; m_fall = 1'b0; m_run = 0;
            m_edges = 0; m_glitches = 0; m_sat = 1'b0;
            return;
        end
        seen  = m_s1;
        m_s1  = m_s0;
        m_s0  = fi;
        m_rise = 1'b0;
        m_fall = 1'b0;
        inc_e = 0;
        inc_g = 0;
        if (!e) begin
            m_run = 0;
        end else if (seen != m_fout) begin
            m_run++;
            if (m_run == MIN_WIDTH) begin
                m_fout = seen;
                m_rise = seen;
                m_fall = !seen;
                inc_e  = 1;
                m_run  = 0;
            end
        end else begin
            if (m_run > 0) inc_g = 1;
            m_run = 0;
        end
        if (c) begin
            m_edges = 0; m_glitches = 0; m_sat = 1'b0;
        end else begin
            if (inc_e) m_edges = (m_edges + 1) % (1 << CNT_W);
            if (inc_g && m_glitches < (1 << CNT_W) - 1) begin
                m_glitches++;
                if (m_glitches == (1 << CNT_W) - 1) m_sat = 1'b1;
            end
        end
    endtask

    // Drive one clock's worth of inputs, then record what the outputs must be after that edge.
    task automatic applyStimulus(input logic r, input logic fi, input logic e, input logic c);
        snap_t s;
        rst = r; f_in = fi; en = e; clr_counts = c;
        @(posedge clk);
        updateModel(r, fi, e, c);
        s.f_out    = m_fout;
        s.rise     = m_rise;
        s.fall     = m_fall;
        s.edges    = CNT_W'(m_edges);
        s.glitches = CNT_W'(m_glitches);
        s.sat      = m_sat;
        exp_q.push_back(s);
        #1;
    endtask

    task automatic checkOutput(input snap_t want);
        snap_t got;
        got = '{f_out, rise_pulse, fall_pulse, edge_count, glitch_count, glitch_sat};
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL outputs cycle %0d: got f_out=%b rise=%b fall=%b edges=%0d glitches=%0d sat=%b, required f_out=%b rise=%b fall=%b edges=%0d glitches=%0d sat=%b",
                     cycle, got.f_out, got.rise, got.fall, got.edges, got.glitches, got.sat,
                     want.f_out, want.rise, want.fall, want.edges, want.glitches, want.sat);
        end
    endtask

    // Monitor: the outputs are registered, so every edge presents a new response to compare.
    always @(negedge clk) begin
        cycle++;
        if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
    end

    initial begin
        int wait_cnt;
        rst = 1'b1; f_in = 1'b1; en = 1'b1; clr_counts = 1'b0;

        $display("[TB] reset");
        for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

        $display("[TB] accepted fall, then accepted rise");
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

        $display("[TB] short glitch rejected");
        for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

        $display("[TB] glitch counter saturation and clear");
        for (int g = 0; g < 300; g++) begin
            for (int i = 0; i < 4; i++) applyStimulus(1'b0, (i >= 2), 1'b1, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);

        $display("[TB] enable held low, then released");
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset mid-candidate, clear on accept edge");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 1'b1, (i == 4));

        $display("[TB] randomized runs");
        for (int r = 0; r < 900; r++) begin
            logic lvl;
            int   len;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
                applyStimulus(($urandom_range(0, 399) == 0), lvl,
                              ($urandom_range(0, 14) != 0), ($urandom_range(0, 79) == 0));
            end
        end

        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(negedge clk);
            wait_cnt++;
        end
        #1;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got %0d pending responses, required 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
